// File: rtl/controle_timeout_pkg.sv
// Shared definitions for the controle_timeout supervisor: 3-bit state encoding.
// State PAUSE is only reachable when CONTROLE_TIMEOUT_PAUSA_EN is defined.
package controle_timeout_pkg;

  localparam int unsigned ESTADO_W = 3;

  typedef enum logic [ESTADO_W-1:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    TIMEOUT = 3'd2,
    DONE    = 3'd3,
    PAUSE   = 3'd4
  } estado_t;

  // Width needed to hold the values 0..n.
  function automatic int unsigned largura_ticks(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/controle_timeout_if.sv
// Control/status bundle between the timeout supervisor and its surroundings.
// Carries pausar only when CONTROLE_TIMEOUT_PAUSA_EN is defined.
interface controle_timeout_if #(
  parameter int unsigned N_TICKS = 5
);
  import controle_timeout_pkg::*;

  localparam int unsigned W = largura_ticks(N_TICKS);

  logic         iniciar;
  logic         parar;
  logic         tick;
`ifdef CONTROLE_TIMEOUT_PAUSA_EN
  logic         pausar;
`endif
  logic         cnt_clr_n;
  logic         cnt_en;
  logic         contando;
  logic         timeout;
  logic         concluido;
  logic [W-1:0] ticks_restantes;

  modport master (
    output iniciar,
    output parar,
    output tick,
`ifdef CONTROLE_TIMEOUT_PAUSA_EN
    output pausar,
`endif
    input  cnt_clr_n,
    input  cnt_en,
    input  contando,
    input  timeout,
    input  concluido,
    input  ticks_restantes
  );

  modport slave (
    input  iniciar,
    input  parar,
    input  tick,
`ifdef CONTROLE_TIMEOUT_PAUSA_EN
    input  pausar,
`endif
    output cnt_clr_n,
    output cnt_en,
    output contando,
    output timeout,
    output concluido,
    output ticks_restantes
  );

endinterface

// File: rtl/controle_timeout.sv
// Timeout supervisor: counts N_TICKS periods of the external 0..2000 counter and drives its clear/enable.
// Optional pause state enabled by defining CONTROLE_TIMEOUT_PAUSA_EN.
module controle_timeout
  import controle_timeout_pkg::*;
#(
  parameter int unsigned N_TICKS = 5
) (
  input logic              clock,
  input logic              reset,
  controle_timeout_if.slave bus
);

  localparam int unsigned W     = largura_ticks(N_TICKS);
  localparam logic [W-1:0] CARGA = W'(N_TICKS);

  estado_t      estado_q, estado_d;
  logic [W-1:0] ticks_q, ticks_d;
  logic         pausar;

`ifdef CONTROLE_TIMEOUT_PAUSA_EN
  assign pausar = bus.pausar;
`else
  assign pausar = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      ticks_q  <= CARGA;
    end else begin
      estado_q <= estado_d;
      ticks_q  <= ticks_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    ticks_d  = ticks_q;
    case (estado_q)
      IDLE: begin
        if (bus.iniciar) begin
          estado_d = RUN;
          ticks_d  = CARGA;
        end
      end
      RUN: begin
        if (bus.iniciar) begin
          ticks_d = CARGA;
        end else if (bus.parar) begin
          estado_d = DONE;
        end else begin
          // A tick coinciding with pausar is still consumed, since the counter clears on it.
          if (bus.tick) begin
            if (ticks_q > W'(1)) begin
              ticks_d = ticks_q - W'(1);
            end else begin
              ticks_d  = '0;
              estado_d = TIMEOUT;
            end
          end
          if (pausar && !(bus.tick && ticks_q <= W'(1))) begin
            estado_d = PAUSE;
          end
        end
      end
      TIMEOUT, DONE: begin
        if (bus.iniciar) begin
          estado_d = RUN;
          ticks_d  = CARGA;
        end
      end
`ifdef CONTROLE_TIMEOUT_PAUSA_EN
      PAUSE: begin
        if (bus.iniciar) begin
          estado_d = RUN;
          ticks_d  = CARGA;
        end else if (bus.parar) begin
          estado_d = DONE;
        end else if (!pausar) begin
          estado_d = RUN;
        end
      end
`endif
      default: estado_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cnt_en    = 1'b0;
    bus.cnt_clr_n = 1'b0;
    case (estado_q)
      RUN: begin
        bus.cnt_en    = 1'b1;
        bus.cnt_clr_n = !(bus.tick || bus.iniciar);
      end
`ifdef CONTROLE_TIMEOUT_PAUSA_EN
      // Counter holds while paused; a restart still begins a fresh period.
      PAUSE: bus.cnt_clr_n = !bus.iniciar;
`endif
      default: bus.cnt_clr_n = 1'b0;
    endcase
  end

  assign bus.contando        = (estado_q == RUN);
  assign bus.timeout         = (estado_q == TIMEOUT);
  assign bus.concluido       = (estado_q == DONE);
  assign bus.ticks_restantes = ticks_q;

endmodule
